// File: rtl/regfile_flags.sv
// regfile_flags: 8 x 16-bit register file with two combinational read ports,
// one synchronous write-back port, and the architectural {Z,C,N} flag register
// that sits between the ALU flag outputs and the ADDC/SUBC carry input.
//
// Optional feature macro: REGFILE_BYPASS_EN
//   When defined, a same-cycle write is forwarded to any read port addressing
//   the written register, and an enabled flag update is forwarded to flag_q.
//   This creates a combinational path from wd to ra_data/rb_data. The
//   controller must register aluout before it reaches wd.
//   When undefined, the read ports and flag_q show stored state only.
//
// Update qualification: stall=1 blocks every register and flag write in the
// cycle where it is high. There is no handshake. A write is accepted at the
// rising edge when its enable is high and stall is low.
module regfile_flags #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3,
    parameter int NREG   = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic [ADDR_W-1:0] ra_addr,
    output logic [DATA_W-1:0] ra_data,
    input  logic [ADDR_W-1:0] rb_addr,
    output logic [DATA_W-1:0] rb_data,
    input  logic              we,
    input  logic [ADDR_W-1:0] wa,
    input  logic [DATA_W-1:0] wd,
    input  logic              flag_we,
    input  logic [2:0]        flag_d,
    output logic [2:0]        flag_q
);

    logic [DATA_W-1:0] regs_q [NREG];
    logic [DATA_W-1:0] regs_d [NREG];
    logic [2:0]        flag_reg_q;
    logic [2:0]        flag_reg_d;
    logic              reg_wr_en;
    logic              flag_wr_en;

    assign reg_wr_en  = we && !stall;
    assign flag_wr_en = flag_we && !stall;

    // Next state of the register array: only the addressed entry can change.
    always_comb begin
        for (int i = 0; i < NREG; i++) begin
            regs_d[i] = regs_q[i];
        end
        if (reg_wr_en) begin
            regs_d[wa] = wd;
        end
    end

    // Next flag state: load new ALU flags when enabled, otherwise hold.
    always_comb begin
        flag_reg_d = flag_reg_q;
        if (flag_wr_en) begin
            flag_reg_d = flag_d;
        end
    end

    // State registers. Asynchronous reset clears every register and the flags,
    // so a write pending when reset asserts is lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
            flag_reg_q <= 3'b000;
        end else begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= regs_d[i];
            end
            flag_reg_q <= flag_reg_d;
        end
    end

    // Read ports: combinational lookup, with optional write-through forwarding.
    always_comb begin
        ra_data = regs_q[ra_addr];
        rb_data = regs_q[rb_addr];
`ifdef REGFILE_BYPASS_EN
        if (reg_wr_en && (wa == ra_addr)) begin
            ra_data = wd;
        end
        if (reg_wr_en && (wa == rb_addr)) begin
            rb_data = wd;
        end
`endif
    end

    // Flag output: stored flags, with optional forwarding of an enabled update.
    always_comb begin
        flag_q = flag_reg_q;
`ifdef REGFILE_BYPASS_EN
        if (flag_wr_en) begin
            flag_q = flag_d;
        end
`endif
    end

endmodule
